// File: rtl/cnt_pkg.sv
// Shared definitions for the cascaded modulo-N counter family.
package cnt_pkg;

  // Count direction encodings as seen on the up input.
  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  // Bits needed to hold 0..v-1. Never returns less than one bit.
  function automatic int unsigned cnt_clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/mod_n_digit.sv
// One modulo-N digit: clear, clamped parallel load, up/down step with wrap,
// plus a terminal flag that depends only on the held value and the direction.
module mod_n_digit import cnt_pkg::*; #(
  parameter int N = 10,
  parameter int W = cnt_clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         tc
);

  localparam logic [W-1:0] MAXV = W'(N - 1);

  logic [W-1:0] load_val;

  // Out-of-range load values saturate at the top code; the compare is done one
  // bit wider so a power-of-two N does not alias to zero.
  always_comb begin
    load_val = d;
    if ({1'b0, d} >= (W + 1)'(N)) load_val = MAXV;
  end

  // Terminal flag: last code in the current direction, independent of en.
  always_comb begin
    tc = (up == CNT_DOWN) ? (q == '0) : (q == MAXV);
  end

  // Digit register: clr beats load beats enabled step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      if (up == CNT_UP) q <= (q == MAXV) ? '0 : q + 1'b1;
      else              q <= (q == '0) ? MAXV : q - 1'b1;
    end
  end

endmodule

// File: rtl/mod_cascade_counter.sv
// Multi-digit modulo-N counter built from a synchronous cascade of digits.
// The carry enable ripples combinationally; every digit shares one clock.
module mod_cascade_counter import cnt_pkg::*; #(
  parameter  int N      = 10,
  parameter  int DIGITS = 2,
  localparam int W      = cnt_clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                up,
  input  logic                clr,
  input  logic                load,
  input  logic [DIGITS*W-1:0] d,
  output logic [DIGITS*W-1:0] q,
  output logic [DIGITS-1:0]   tc,
  output logic                ov
);

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic dig_en;

    if (k == 0) begin : g_first
      // Lowest digit steps on every enabled cycle.
      always_comb begin
        dig_en = ce;
      end
    end else begin : g_upper
      // Higher digit steps only when every lower digit is at its terminal code.
      // Each digit ANDs tc directly rather than chaining dig_en, so no net
      // feeds back on itself.
      always_comb begin
        dig_en = ce;
        for (int unsigned j = 0; j < k; j++) dig_en = dig_en & tc[j];
      end
    end

    mod_n_digit #(.N(N), .W(W)) u_digit (
      .clk  (clk),
      .rst  (rst),
      .en   (dig_en),
      .up   (up),
      .clr  (clr),
      .load (load),
      .d    (d[k*W +: W]),
      .q    (q[k*W +: W]),
      .tc   (tc[k])
    );
  end

  // Whole-counter wrap indicator for the cycle whose edge wraps every digit.
  always_comb begin
    ov = ce & ~clr & ~load & (&tc);
  end

endmodule

// File: tb/tb_mod_cascade_counter.sv
// Bench for mod_cascade_counter: N=10/DIGITS=2 instance checked against an
// integer-valued model, plus an N=16/DIGITS=3 instance for full-range wrap.
module tb_mod_cascade_counter;

  logic        clk;
  logic        rst;
  logic        ce, up, clr, load;
  logic [7:0]  d;
  logic [7:0]  q;
  logic [1:0]  tc;
  logic        ov;

  logic        ceb, upb, clrb, loadb;
  logic [11:0] db;
  logic [11:0] qb;
  logic [2:0]  tcb;
  logic        ovb;

  int n_cmp;
  int n_bad;
  int ma;
  logic pre_ov;

  mod_cascade_counter #(.N(10), .DIGITS(2)) dut_a (
    .clk(clk), .rst(rst), .ce(ce), .up(up), .clr(clr), .load(load),
    .d(d), .q(q), .tc(tc), .ov(ov)
  );

  mod_cascade_counter #(.N(16), .DIGITS(3)) dut_b (
    .clk(clk), .rst(rst), .ce(ceb), .up(upb), .clr(clrb), .load(loadb),
    .d(db), .q(qb), .tc(tcb), .ov(ovb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ce, up, clr, load;
    logic [7:0] d;
    logic [7:0] eq;
    logic       eov;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model helpers: the counter value is a plain integer 0..99.
  function automatic logic [7:0] enc(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [1:0] tc_model(input int v, input logic u);
    int d0, d1;
    d0 = v % 10;
    d1 = v / 10;
    if (u) return {d1 == 9, d0 == 9};
    else   return {d1 == 0, d0 == 0};
  endfunction

  function automatic int clamp9(input logic [3:0] x);
    return (int'(x) > 9) ? 9 : int'(x);
  endfunction

  // One clock of dut_a: drive, compare combinational outputs, clock, compare q.
  task automatic cyc(input logic c_ce, input logic c_up, input logic c_clr,
                     input logic c_load, input logic [7:0] c_d);
    logic eov;
    ce = c_ce; up = c_up; clr = c_clr; load = c_load; d = c_d;
    #1;
    eov = c_ce & ~c_clr & ~c_load & (&tc_model(ma, c_up));
    chk("q_pre", {24'd0, q}, {24'd0, enc(ma)});
    chk("tc", {30'd0, tc}, {30'd0, tc_model(ma, c_up)});
    chk("ov", {31'd0, ov}, {31'd0, eov});
    pre_ov = ov;
    @(posedge clk);
    if (c_clr)       ma = 0;
    else if (c_load) ma = clamp9(c_d[7:4]) * 10 + clamp9(c_d[3:0]);
    else if (c_ce)   ma = c_up ? (ma + 1) % 100 : (ma + 99) % 100;
    #1;
    chk("q_post", {24'd0, q}, {24'd0, enc(ma)});
  endtask

  initial begin
    int ovcnt;
    n_cmp = 0; n_bad = 0; ma = 0; pre_ov = 1'b0;
    rst = 1'b0; ce = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; d = '0;
    ceb = 1'b0; upb = 1'b1; clrb = 1'b0; loadb = 1'b0; db = '0;

    tbl[0] = '{ce:1, up:1, clr:0, load:1, d:8'h7C, eq:8'h79, eov:0};
    tbl[1] = '{ce:0, up:1, clr:0, load:1, d:8'h45, eq:8'h45, eov:0};
    tbl[2] = '{ce:1, up:1, clr:1, load:1, d:8'h33, eq:8'h00, eov:0};
    tbl[3] = '{ce:1, up:1, clr:0, load:0, d:8'h00, eq:8'h01, eov:0};
    tbl[4] = '{ce:0, up:1, clr:0, load:0, d:8'h00, eq:8'h01, eov:0};
    tbl[5] = '{ce:1, up:1, clr:0, load:0, d:8'h00, eq:8'h02, eov:0};
    tbl[6] = '{ce:0, up:1, clr:0, load:1, d:8'hFF, eq:8'h99, eov:0};
    tbl[7] = '{ce:1, up:1, clr:0, load:0, d:8'h00, eq:8'h00, eov:1};
    tbl[8] = '{ce:1, up:0, clr:0, load:0, d:8'h00, eq:8'h99, eov:1};
    tbl[9] = '{ce:0, up:1, clr:0, load:0, d:8'h00, eq:8'h99, eov:0};

    // Reset held with ce high: q stays zero.
    ce = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_hold_q", {24'd0, q}, 32'd0);
    end
    chk("rst_hold_tc", {30'd0, tc}, 32'd0);
    rst = 1'b1;
    ma = 0;

    // Count up to 99.
    repeat (99) cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("t1_q99", {24'd0, q}, 32'h99);
    chk("t1_tc11", {30'd0, tc}, 32'd3);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("t1_wrap_ov", {31'd0, pre_ov}, 32'd1);
    chk("t1_wrap_q", {24'd0, q}, 32'h00);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("t1_ov_once", {31'd0, pre_ov}, 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);

    // Count down from 00.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("t2_ov", {31'd0, pre_ov}, 32'd1);
    chk("t2_q99", {24'd0, q}, 32'h99);
    repeat (10) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("t2_q89", {24'd0, q}, 32'h89);

    // Load/clear priority and gated stepping.
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].ce, tbl[i].up, tbl[i].clr, tbl[i].load, tbl[i].d);
      chk($sformatf("tbl%0d_ov", i), {31'd0, pre_ov}, {31'd0, tbl[i].eov});
      chk($sformatf("tbl%0d_q", i), {24'd0, q}, {24'd0, tbl[i].eq});
    end

    // Asynchronous reset mid-cycle.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h37);
    ce = 1'b1; up = 1'b1; clr = 1'b0; load = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("t5_async_q", {24'd0, q}, 32'd0);
    chk("t5_async_ov", {31'd0, ov}, 32'd0);
    ma = 0;
    #1 rst = 1'b1;
    @(posedge clk);
    ma = 1;
    #1;
    chk("t5_resume_q", {24'd0, q}, 32'h01);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 4) != 0, 1'($urandom), ($urandom % 16) == 0,
          ($urandom % 12) == 0, 8'($urandom));
    end

    // Full-range wrap of the 3-digit modulus-16 counter.
    chk("t6_start_q", {20'd0, qb}, 32'd0);
    ceb = 1'b1; upb = 1'b1;
    ovcnt = 0;
    for (int i = 0; i < 4096; i++) begin
      #1;
      if (ovb) ovcnt++;
      if (i == 4095) chk("t6_ov_last", {31'd0, ovb}, 32'd1);
      @(posedge clk); #1;
      chk("t6_q", {20'd0, qb}, 32'((i + 1) % 4096));
    end
    chk("t6_ov_count", 32'(ovcnt), 32'd1);
    chk("t6_end_q", {20'd0, qb}, 32'd0);
    ceb = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case the run never reaches its summary.
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
